// File: rtl/egress_interface_depacketizer.sv
// Egress depacketizer: takes 144-bit packets from the layer-engine network,
// keeps those addressed to this endpoint (or broadcast, or everything when
// filtering is off), strips the header and hands the payload on through a
// two-entry buffer. Rejected packets are still consumed and are counted.
module egress_interface_depacketizer #(
   parameter int C_PACKET_PAYLOAD_WIDTH = 128,
   parameter int C_PACKET_HEADER_WIDTH  = 16,
   parameter int C_PACKET_WIDTH         = C_PACKET_PAYLOAD_WIDTH + C_PACKET_HEADER_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              filter_en,
   input  logic [11:0]                       local_address,
   input  logic                              drop_count_clear,
   input  logic                              ingress_valid,
   output logic                              ingress_ready,
   input  logic [C_PACKET_WIDTH-1:0]         ingress_data,
   output logic                              egress_valid,
   input  logic                              egress_ready,
   output logic [C_PACKET_PAYLOAD_WIDTH-1:0] egress_data,
   output logic [11:0]                       egress_dest,
   output logic [15:0]                       drop_count
);

   // Buffer occupancy states
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam logic [11:0] BROADCAST_ADDR = 12'hFFF;

   logic [1:0]                        state_q, state_d;
   logic [C_PACKET_PAYLOAD_WIDTH-1:0] headData_q, headData_d;
   logic [11:0]                       headDest_q, headDest_d;
   logic [C_PACKET_PAYLOAD_WIDTH-1:0] tailData_q, tailData_d;
   logic [11:0]                       tailDest_q, tailDest_d;
   logic [15:0]                       dropCount_q, dropCount_d;

   logic [11:0]                       pktDest;
   logic [C_PACKET_PAYLOAD_WIDTH-1:0] pktPayload;
   logic [C_PACKET_HEADER_WIDTH-13:0] headerReservedUnused;
   logic                              addrMatch;
   logic                              forwardPkt;
   logic                              inXfer;
   logic                              push;
   logic                              drop;
   logic                              pop;

   // Header layout: destination in the low 12 header bits, the top nibble is reserved
   assign pktDest              = ingress_data[C_PACKET_PAYLOAD_WIDTH +: 12];
   assign pktPayload           = ingress_data[C_PACKET_PAYLOAD_WIDTH-1:0];
   assign headerReservedUnused = ingress_data[C_PACKET_WIDTH-1 -: (C_PACKET_HEADER_WIDTH-12)];

   // Ready depends only on registered state and reset, never on egress_ready,
   // so a dropped packet also waits while the buffer is full
   assign ingress_ready = ~rst & (state_q != ST_FULL);
   assign egress_valid  = (state_q != ST_EMPTY);
   assign egress_data   = headData_q;
   assign egress_dest   = headDest_q;
   assign drop_count    = dropCount_q;

   assign addrMatch  = (pktDest == local_address) | (pktDest == BROADCAST_ADDR);
   assign forwardPkt = addrMatch | ~filter_en;
   assign inXfer     = ingress_valid & ingress_ready;
   assign push       = inXfer & forwardPkt;
   assign drop       = inXfer & ~forwardPkt;
   assign pop        = egress_valid & egress_ready;

   // Next-state for the occupancy FSM and the head/tail entries
   always_comb begin
      state_d    = state_q;
      headData_d = headData_q;
      headDest_d = headDest_q;
      tailData_d = tailData_q;
      tailDest_d = tailDest_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               headData_d = pktPayload;
               headDest_d = pktDest;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               headData_d = pktPayload;
               headDest_d = pktDest;
            end else if (push) begin
               tailData_d = pktPayload;
               tailDest_d = pktDest;
               state_d    = ST_FULL;
            end else if (pop) begin
               state_d    = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               headData_d = tailData_q;
               headDest_d = tailDest_q;
               state_d    = ST_ONE;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Saturating drop counter; a clear in the same cycle as a drop leaves one
   always_comb begin
      dropCount_d = dropCount_q;
      if (drop_count_clear) begin
         dropCount_d = drop ? 16'd1 : 16'd0;
      end else if (drop && (dropCount_q != 16'hFFFF)) begin
         dropCount_d = dropCount_q + 16'd1;
      end
   end

   // Register update with synchronous reset discarding any buffered packets
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         headData_q  <= '0;
         headDest_q  <= '0;
         tailData_q  <= '0;
         tailDest_q  <= '0;
         dropCount_q <= '0;
      end else begin
         state_q     <= state_d;
         headData_q  <= headData_d;
         headDest_q  <= headDest_d;
         tailData_q  <= tailData_d;
         tailDest_q  <= tailDest_d;
         dropCount_q <= dropCount_d;
      end
   end

endmodule

// File: tb/tb_egress_interface_depacketizer.sv
// Testbench for the egress depacketizer: a queue-based reference model of the
// buffer and drop counter is compared against the DUT on every falling edge,
// with directed scenarios and a randomized stretch driving the inputs.
module tb_egress_interface_depacketizer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         filter_en = 1'b0;
   logic [11:0]  local_address = 12'h000;
   logic         drop_count_clear = 1'b0;
   logic         ingress_valid = 1'b0;
   logic         ingress_ready;
   logic [143:0] ingress_data = '0;
   logic         egress_valid;
   logic         egress_ready = 1'b0;
   logic [127:0] egress_data;
   logic [11:0]  egress_dest;
   logic [15:0]  drop_count;

   int checks = 0;
   int failures = 0;

   logic [139:0] modelQ[$];
   int           modelDrop = 0;
   logic [139:0] obsQ[$];

   logic [11:0]  mDest;
   bit           mAcc, mFwd, mPop, mDrp;

   egress_interface_depacketizer dut (
      .clk              (clk),
      .rst              (rst),
      .filter_en        (filter_en),
      .local_address    (local_address),
      .drop_count_clear (drop_count_clear),
      .ingress_valid    (ingress_valid),
      .ingress_ready    (ingress_ready),
      .ingress_data     (ingress_data),
      .egress_valid     (egress_valid),
      .egress_ready     (egress_ready),
      .egress_data      (egress_data),
      .egress_dest      (egress_dest),
      .drop_count       (drop_count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [143:0] actual, input logic [143:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a FIFO of at most two forwarded packets plus a saturating counter
   always @(posedge clk) begin
      if (rst) begin
         modelQ.delete();
         modelDrop = 0;
      end else begin
         mDest = ingress_data[139:128];
         mAcc  = ingress_valid && (modelQ.size() < 2);
         mFwd  = !filter_en || (mDest == local_address) || (mDest == 12'hFFF);
         mPop  = (modelQ.size() > 0) && egress_ready;
         mDrp  = mAcc && !mFwd;
         if (mPop) void'(modelQ.pop_front());
         if (mAcc && mFwd) modelQ.push_back({mDest, ingress_data[127:0]});
         if (drop_count_clear) modelDrop = mDrp ? 1 : 0;
         else if (mDrp && modelDrop < 65535) modelDrop++;
      end
   end

   // Compare DUT against the model away from the active edge and log deliveries
   always @(negedge clk) begin
      checkOutput("ingress_ready", 144'(ingress_ready), 144'(!rst && (modelQ.size() < 2)));
      checkOutput("egress_valid", 144'(egress_valid), 144'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
         checkOutput("egress_data", 144'(egress_data), 144'(modelQ[0][127:0]));
         checkOutput("egress_dest", 144'(egress_dest), 144'(modelQ[0][139:128]));
      end
      checkOutput("drop_count", 144'(drop_count), 144'(modelDrop));
      if (!rst && egress_valid && egress_ready) obsQ.push_back({egress_dest, egress_data});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [11:0] dest, input logic [127:0] payload);
      ingress_valid = valid;
      ingress_data  = {4'($urandom), dest, payload};
   endtask

   task automatic idle(input int n);
      ingress_valid = 1'b0;
      repeat (n) step();
   endtask

   // Present a packet and hold it until the handshake completes (bounded)
   task automatic sendPacket(input logic [11:0] dest, input logic [127:0] payload);
      bit acc;
      acc = 1'b0;
      applyStimulus(1'b1, dest, payload);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         acc = ingress_ready;
         step();
         if (acc) break;
      end
      if (!acc) checkOutput("send_timeout", 144'(0), 144'(1));
   endtask

   task automatic checkObs(input string name, input int idx, input logic [11:0] dest, input logic [127:0] payload);
      logic [139:0] entry;
      if (idx < obsQ.size()) begin
         entry = obsQ[idx];
         checkOutput(name, 144'(entry), 144'({dest, payload}));
      end else begin
         checkOutput(name, 144'(obsQ.size()), 144'(idx + 1));
      end
   endtask

   initial begin
      int readyLow;
      int validGaps;
      logic [11:0] rDest;

      // Reset state
      repeat (3) step();
      checkOutput("reset_ingress_ready", 144'(ingress_ready), 144'(0));
      checkOutput("reset_egress_valid", 144'(egress_valid), 144'(0));
      checkOutput("reset_egress_data", 144'(egress_data), 144'(0));
      checkOutput("reset_egress_dest", 144'(egress_dest), 144'(0));
      checkOutput("reset_drop_count", 144'(drop_count), 144'(0));
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 144'(ingress_ready), 144'(1));

      // Single matching packet, one-cycle latency
      filter_en     = 1'b1;
      local_address = 12'h005;
      egress_ready  = 1'b1;
      applyStimulus(1'b1, 12'h005, {16{8'hA5}});
      step();
      ingress_valid = 1'b0;
      checkOutput("first_valid", 144'(egress_valid), 144'(1));
      checkOutput("first_data", 144'(egress_data), 144'({16{8'hA5}}));
      checkOutput("first_dest", 144'(egress_dest), 144'(12'h005));
      checkOutput("first_drop", 144'(drop_count), 144'(0));
      idle(2);

      // Mixed stream with filtering on, then off
      obsQ.delete();
      sendPacket(12'h005, 128'h1);
      sendPacket(12'h007, 128'h2);
      sendPacket(12'hFFF, 128'h3);
      sendPacket(12'h003, 128'h4);
      idle(4);
      checkOutput("mixed_filter_count", 144'(obsQ.size()), 144'(2));
      checkObs("mixed_filter_0", 0, 12'h005, 128'h1);
      checkObs("mixed_filter_1", 1, 12'hFFF, 128'h3);
      checkOutput("mixed_filter_drops", 144'(drop_count), 144'(2));
      drop_count_clear = 1'b1;
      step();
      drop_count_clear = 1'b0;
      checkOutput("clear_alone", 144'(drop_count), 144'(0));
      filter_en = 1'b0;
      obsQ.delete();
      sendPacket(12'h005, 128'h11);
      sendPacket(12'h007, 128'h12);
      sendPacket(12'hFFF, 128'h13);
      sendPacket(12'h003, 128'h14);
      idle(4);
      checkOutput("mixed_nofilter_count", 144'(obsQ.size()), 144'(4));
      checkObs("mixed_nofilter_1", 1, 12'h007, 128'h12);
      checkObs("mixed_nofilter_3", 3, 12'h003, 128'h14);
      checkOutput("mixed_nofilter_drops", 144'(drop_count), 144'(0));

      // Backpressure: third packet held until space frees
      filter_en    = 1'b1;
      egress_ready = 1'b0;
      obsQ.delete();
      applyStimulus(1'b1, 12'h005, 128'hB1);
      step();
      applyStimulus(1'b1, 12'h005, 128'hB2);
      step();
      applyStimulus(1'b1, 12'h005, 128'hB3);
      step();
      checkOutput("full_ready_low", 144'(ingress_ready), 144'(0));
      step();
      checkOutput("full_ready_held", 144'(ingress_ready), 144'(0));
      egress_ready = 1'b1;
      sendPacket(12'h005, 128'hB3);
      idle(4);
      checkOutput("bp_count", 144'(obsQ.size()), 144'(3));
      checkObs("bp_0", 0, 12'h005, 128'hB1);
      checkObs("bp_1", 1, 12'h005, 128'hB2);
      checkObs("bp_2", 2, 12'h005, 128'hB3);

      // Back-to-back throughput
      obsQ.delete();
      readyLow  = 0;
      validGaps = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 12'h005 : 12'hFFF, 128'(i));
         @(negedge clk);
         if (!ingress_ready) readyLow++;
         if (i > 0 && !egress_valid) validGaps++;
         step();
      end
      idle(3);
      checkOutput("b2b_ready_low", 144'(readyLow), 144'(0));
      checkOutput("b2b_valid_gaps", 144'(validGaps), 144'(0));
      checkOutput("b2b_count", 144'(obsQ.size()), 144'(100));
      checkObs("b2b_last", 99, 12'hFFF, 128'd99);

      // Drop counter saturation and clear behaviour
      applyStimulus(1'b1, 12'h007, 128'hDEAD);
      repeat (65540) step();
      checkOutput("drop_saturated", 144'(drop_count), 144'(16'hFFFF));
      drop_count_clear = 1'b1;
      step();
      drop_count_clear = 1'b0;
      ingress_valid    = 1'b0;
      checkOutput("clear_with_drop", 144'(drop_count), 144'(1));
      drop_count_clear = 1'b1;
      step();
      drop_count_clear = 1'b0;
      checkOutput("clear_only", 144'(drop_count), 144'(0));

      // Reset while full discards stale packets
      egress_ready = 1'b0;
      obsQ.delete();
      sendPacket(12'h005, 128'h5A1E1);
      sendPacket(12'h005, 128'h5A1E2);
      ingress_valid = 1'b0;
      checkOutput("pre_reset_full", 144'(ingress_ready), 144'(0));
      rst = 1'b1;
      step();
      checkOutput("reset_mid_valid", 144'(egress_valid), 144'(0));
      checkOutput("reset_mid_ready", 144'(ingress_ready), 144'(0));
      rst          = 1'b0;
      egress_ready = 1'b1;
      sendPacket(12'h005, 128'hF00D);
      idle(3);
      checkOutput("post_reset_count", 144'(obsQ.size()), 144'(1));
      checkObs("post_reset_pkt", 0, 12'h005, 128'hF00D);

      // Randomized traffic checked by the model
      local_address = 12'h2A3;
      for (int i = 0; i < 3000; i++) begin
         if (i % 256 == 0) filter_en = 1'($urandom);
         case ($urandom_range(0, 2))
            0: rDest = local_address;
            1: rDest = 12'hFFF;
            default: rDest = 12'($urandom);
         endcase
         applyStimulus(($urandom_range(0, 3) != 0), rDest, {$urandom, $urandom, $urandom, $urandom});
         egress_ready     = ($urandom_range(0, 9) < 7);
         drop_count_clear = ($urandom_range(0, 49) == 0);
         step();
      end
      drop_count_clear = 1'b0;
      egress_ready     = 1'b1;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
